// File: rtl/freq_divider_prog_if.sv
`default_nettype none
// ============================================================================
//  Module      : freq_divider_prog_if
//  Description : Control/status bundle of the programmable clock divider.
//                The master drives run and divisor requests, the slave (the
//                divider) returns the divided clock and status pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface freq_divider_prog_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic             period_tick;
  logic             div_ack;
  logic             div_err;
  logic             busy;

  modport master (
    output en,
    output div_in,
    output div_load,
    input  clk_out,
    input  period_tick,
    input  div_ack,
    input  div_err,
    input  busy
  );

  modport slave (
    input  en,
    input  div_in,
    input  div_load,
    output clk_out,
    output period_tick,
    output div_ack,
    output div_err,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/freq_divider_prog.sv
`default_nettype none
// ============================================================================
//  Module      : freq_divider_prog
//  Description : Programmable integer clock divider with 50% duty for both
//                even and odd ratios. Divisor changes are staged and only
//                take effect on a period boundary, so clk_out never produces
//                a runt phase. A stopped divider finishes its current period
//                (DRAIN) before going idle with clk_out held low.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_divider_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic               clk_in,
  input  logic               nreset,
  freq_divider_prog_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);
  localparam logic [WIDTH:0]   c_one_ext     = (WIDTH+1)'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_div, w_div_nxt;
  logic [WIDTH-1:0] r_pend_div, w_pend_div_nxt;
  logic             r_pend_vld, w_pend_vld_nxt;
  logic             r_hi_p, w_hi_p_nxt;
  logic             r_hi_n;
  logic             r_tick, w_tick_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_err, w_err_nxt;
  logic             w_wrap, w_apply, w_load_ok;
  logic [WIDTH:0]   w_half;

  // Next-state, counter, divisor staging and output-flop inputs
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_div_nxt      = r_div;
    w_pend_div_nxt = r_pend_div;
    w_pend_vld_nxt = r_pend_vld;
    w_hi_p_nxt     = 1'b0;
    w_tick_nxt     = 1'b0;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_half         = '0;

    // Last cycle of the current period while the counter is running
    w_wrap    = (r_state != S_IDLE) && (r_cnt == (r_div - c_one));
    // A staged divisor is taken over only at a period boundary or when idle
    w_apply   = r_pend_vld && ((r_state == S_IDLE) || w_wrap);
    w_load_ok = bus.div_load && (bus.div_in > c_one);

    case (r_state)
      S_IDLE:  if (bus.en) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!bus.en) w_state_nxt = w_wrap ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.en)      w_state_nxt = S_RUN;
        else if (w_wrap) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Apply the old pending value first; a coincident legal load then
    // re-stages, so the newest request stays pending.
    if (w_apply) begin
      w_div_nxt      = r_pend_div;
      w_pend_vld_nxt = 1'b0;
    end
    if (w_load_ok) begin
      w_pend_div_nxt = bus.div_in;
      w_pend_vld_nxt = 1'b1;
    end
    w_ack_nxt = w_apply;
    w_err_nxt = bus.div_load && !w_load_ok;

    // Counter restarts at 0 when leaving IDLE and wraps at N-1
    if ((w_state_nxt == S_IDLE) || (r_state == S_IDLE) || w_wrap) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + c_one;
    end

    // High phase covers the first ceil(N/2) counts; compared at WIDTH+1 bits
    w_half     = ({1'b0, w_div_nxt} + c_one_ext) >> 1;
    w_hi_p_nxt = (w_state_nxt != S_IDLE) && ({1'b0, w_cnt_nxt} < w_half);
    w_tick_nxt = (w_state_nxt != S_IDLE) && (w_cnt_nxt == '0);
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Counter, divisor registers and registered status pulses
  always_ff @(posedge clk_in or negedge nreset) begin
    if (!nreset) begin
      r_cnt      <= '0;
      r_div      <= c_default_div;
      r_pend_div <= c_default_div;
      r_pend_vld <= 1'b0;
      r_hi_p     <= 1'b0;
      r_tick     <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_div      <= w_div_nxt;
      r_pend_div <= w_pend_div_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_hi_p     <= w_hi_p_nxt;
      r_tick     <= w_tick_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Half-cycle delayed copy of the high phase for odd-ratio shaping
  always_ff @(negedge clk_in or negedge nreset) begin
    if (!nreset) r_hi_n <= 1'b0;
    else         r_hi_n <= r_hi_p;
  end

  // Odd ratios AND the two phases to trim the high time by half a cycle
  assign bus.clk_out     = r_div[0] ? (r_hi_p & r_hi_n) : r_hi_p;
  assign bus.period_tick = r_tick;
  assign bus.div_ack     = r_ack;
  assign bus.div_err     = r_err;
  assign bus.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
